handwrite_canvas: RTL and testbench

- Producer side of the digit-classifier interface.
- Accumulates pen/touch samples in screen coordinates into a 30x30 bitmap.
- Freezes the bitmap and fires the classifier's active-low start strobe.
- Waits for the classifier's one-cycle result pulse, then holds the recognised digit for display. Sits between the touch/mouse front end and the classifier.

---
 rtl/handwrite_pkg.sv | 25 ++
 rtl/handwrite_cell_map.sv | 39 +++
 rtl/handwrite_canvas.sv | 184 ++++++++++++++++++
 tb/tb_handwrite_canvas.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handwrite_pkg.sv
// Shared definitions for the handwriting canvas: grid geometry, the
// controller state encoding and the cell coordinate type.
package handwrite_pkg;

    localparam int GRID_W    = 30;
    localparam int GRID_H    = 30;
    localparam int GRID_BITS = GRID_W * GRID_H;
    localparam int IDX_W     = $clog2(GRID_BITS);

    // Row or column index inside the 30x30 grid.
    typedef logic [4:0] cell_t;

    typedef enum logic [1:0] {
        S_DRAW,
        S_CLEAR,
        S_FIRE,
        S_WAIT
    } state_e;

    // Flat bitmap index of a grid cell (row-major, 30 cells per row).
    function automatic logic [IDX_W-1:0] cell_index(input cell_t row, input cell_t col);
        return IDX_W'(int'(row) * GRID_W + int'(col));
    endfunction

endpackage

// File: rtl/handwrite_cell_map.sv
// Screen-to-grid mapping: converts a pen position in screen pixels into a
// grid row/column and flags samples that fall outside the 30x30 canvas.
module handwrite_cell_map
    import handwrite_pkg::*;
#(
    parameter int ORIGIN_X   = 80,
    parameter int ORIGIN_Y   = 0,
    parameter int CELL_SHIFT = 4,
    parameter int COORD_W    = 10
) (
    input  logic [COORD_W-1:0] i_pen_x,
    input  logic [COORD_W-1:0] i_pen_y,
    output cell_t              o_row,
    output cell_t              o_col,
    output logic               o_in_range
);

    localparam logic [COORD_W-1:0] ORG_X = COORD_W'(ORIGIN_X);
    localparam logic [COORD_W-1:0] ORG_Y = COORD_W'(ORIGIN_Y);

    logic [COORD_W:0]   dx_ext;
    logic [COORD_W:0]   dy_ext;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;

    // Subtract the origin with one extra bit so a pen left of / above the
    // canvas shows up as a borrow instead of wrapping into a valid cell.
    always_comb begin
        dx_ext     = {1'b0, i_pen_x} - {1'b0, ORG_X};
        dy_ext     = {1'b0, i_pen_y} - {1'b0, ORG_Y};
        cx         = dx_ext[COORD_W-1:0] >> CELL_SHIFT;
        cy         = dy_ext[COORD_W-1:0] >> CELL_SHIFT;
        o_in_range = !dx_ext[COORD_W] && !dy_ext[COORD_W]
                     && (cx < COORD_W'(GRID_W)) && (cy < COORD_W'(GRID_H));
        o_col      = cell_t'(cx);
        o_row      = cell_t'(cy);
    end

endmodule

// File: rtl/handwrite_canvas.sv
// Handwriting canvas: paints pen samples into a 30x30 bitmap, clears it one
// row per cycle, and hands the frozen bitmap to the digit classifier with an
// active-low start strobe, then latches the result (or a timeout).
// Optional feature: define HANDWRITE_THICK_BRUSH_EN for a 3x3 brush.
module handwrite_canvas
    import handwrite_pkg::*;
#(
    parameter int ORIGIN_X    = 80,
    parameter int ORIGIN_Y    = 0,
    parameter int CELL_SHIFT  = 4,
    parameter int COORD_W     = 10,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pen_valid,
    input  logic [COORD_W-1:0]   i_pen_x,
    input  logic [COORD_W-1:0]   i_pen_y,
    input  logic                 i_clear,
    input  logic                 i_submit,
    output logic [GRID_BITS-1:0] o_handwrite,
    output logic                 o_classify_n,
    input  logic [3:0]           i_digit,
    input  logic                 i_digit_valid,
    output logic [3:0]           o_digit,
    output logic                 o_digit_valid,
    output logic                 o_busy,
    output logic                 o_timeout
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam cell_t            LAST_ROW = cell_t'(GRID_H - 1);

    state_e                 state_q, state_d;
    logic [GRID_BITS-1:0]   bitmap_q, bitmap_d;
    logic                   classify_n_q, classify_n_d;
    logic [3:0]             digit_q, digit_d;
    logic                   digit_valid_q, digit_valid_d;
    logic                   timeout_q, timeout_d;
    cell_t                  row_cnt_q, row_cnt_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;

    cell_t                  pen_row;
    cell_t                  pen_col;
    logic                   pen_in_range;

    handwrite_cell_map #(
        .ORIGIN_X   (ORIGIN_X),
        .ORIGIN_Y   (ORIGIN_Y),
        .CELL_SHIFT (CELL_SHIFT),
        .COORD_W    (COORD_W)
    ) u_cell_map (
        .i_pen_x    (i_pen_x),
        .i_pen_y    (i_pen_y),
        .o_row      (pen_row),
        .o_col      (pen_col),
        .o_in_range (pen_in_range)
    );

    // Returns the bitmap with the brush footprint at (row, col) painted in.
    function automatic logic [GRID_BITS-1:0] paint(input logic [GRID_BITS-1:0] bm,
                                                   input cell_t row, input cell_t col);
`ifdef HANDWRITE_THICK_BRUSH_EN
        int r;
        int c;
`endif
        logic [GRID_BITS-1:0] res;
        res = bm;
`ifdef HANDWRITE_THICK_BRUSH_EN
        // 3x3 block centred on the sample, clipped at the grid edges.
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(row) + dr;
                c = int'(col) + dc;
                if (r >= 0 && r < GRID_H && c >= 0 && c < GRID_W) begin
                    res[cell_index(cell_t'(r), cell_t'(c))] = 1'b1;
                end
            end
        end
`else
        res[cell_index(row, col)] = 1'b1;
`endif
        return res;
    endfunction

    // State register and all registered outputs.
    // NOTE: the bitmap is ordinary flops, not a RAM, so it takes the async
    // reset like everything else and reset really does blank the canvas.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_DRAW;
            bitmap_q      <= '0;
            classify_n_q  <= 1'b1;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            row_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q       <= state_d;
            bitmap_q      <= bitmap_d;
            classify_n_q  <= classify_n_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            timeout_q     <= timeout_d;
            row_cnt_q     <= row_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    // Next-state logic: drawing, row-by-row clear, strobe and result wait.
    always_comb begin
        // NOTE: every target gets its hold value first; a path that forgets
        // to assign one would otherwise infer a latch.
        state_d       = state_q;
        bitmap_d      = bitmap_q;
        classify_n_d  = classify_n_q;
        digit_d       = digit_q;
        digit_valid_d = digit_valid_q;
        timeout_d     = timeout_q;
        row_cnt_d     = row_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;

        case (state_q)
            S_DRAW: begin
                if (i_clear) begin
                    digit_valid_d = 1'b0;
                    timeout_d     = 1'b0;
                    row_cnt_d     = '0;
                    state_d       = S_CLEAR;
                end else if (i_submit) begin
                    digit_valid_d = 1'b0;
                    timeout_d     = 1'b0;
                    classify_n_d  = 1'b0;
                    state_d       = S_FIRE;
                end else if (i_pen_valid && pen_in_range) begin
                    bitmap_d = paint(bitmap_q, pen_row, pen_col);
                end
            end

            S_CLEAR: begin
                bitmap_d[cell_index(row_cnt_q, '0) +: GRID_W] = '0;
                if (row_cnt_q == LAST_ROW) begin
                    state_d = S_DRAW;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end

            S_FIRE: begin
                classify_n_d = 1'b1;
                tmo_cnt_d    = '0;
                state_d      = S_WAIT;
            end

            S_WAIT: begin
                // A result arriving on the final count still wins.
                if (i_digit_valid) begin
                    digit_d       = i_digit;
                    digit_valid_d = 1'b1;
                    state_d       = S_DRAW;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DRAW;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            default: state_d = S_DRAW;
        endcase
    end

    assign o_handwrite   = bitmap_q;
    assign o_classify_n  = classify_n_q;
    assign o_digit       = digit_q;
    assign o_digit_valid = digit_valid_q;
    assign o_timeout     = timeout_q;
    assign o_busy        = (state_q != S_DRAW);

endmodule

// File: tb/tb_handwrite_canvas.sv
// Self-checking bench for handwrite_canvas: table-driven pen vectors against a
// bitmap model through a scoreboard queue, plus hand-written clear, classify,
// timeout, result/timeout race and mid-operation reset sequences.
module tb_handwrite_canvas;
    import handwrite_pkg::*;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic                 i_pen_valid = 1'b0;
    logic [9:0]           i_pen_x = '0;
    logic [9:0]           i_pen_y = '0;
    logic                 i_clear = 1'b0;
    logic                 i_submit = 1'b0;
    logic [GRID_BITS-1:0] o_handwrite;
    logic                 o_classify_n;
    logic [3:0]           i_digit = '0;
    logic                 i_digit_valid = 1'b0;
    logic [3:0]           o_digit;
    logic                 o_digit_valid;
    logic                 o_busy;
    logic                 o_timeout;

    always #5 i_clk = ~i_clk;

    handwrite_canvas dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pen_valid   (i_pen_valid),
        .i_pen_x       (i_pen_x),
        .i_pen_y       (i_pen_y),
        .i_clear       (i_clear),
        .i_submit      (i_submit),
        .o_handwrite   (o_handwrite),
        .o_classify_n  (o_classify_n),
        .i_digit       (i_digit),
        .i_digit_valid (i_digit_valid),
        .o_digit       (o_digit),
        .o_digit_valid (o_digit_valid),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [GRID_BITS-1:0] model_bm = '0;
    logic [GRID_BITS-1:0] exp_q[$];

    typedef struct {
        int x;
        int y;
        bit valid;
    } pen_vec_t;

    pen_vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bm(input string name, input logic [GRID_BITS-1:0] act,
                            input logic [GRID_BITS-1:0] exp);
        int first;
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            first = -1;
            for (int i = GRID_BITS - 1; i >= 0; i--) begin
                if (act[i] !== exp[i]) first = i;
            end
            $display("FAIL %s: bitmap has %0d bits set, expected %0d; first differing bit %0d",
                     name, $countones(act), $countones(exp), first);
        end
    endtask

    // Independent model of the screen-to-grid mapping (80 px left margin, 16 px cells).
    function automatic bit map_pen(input int x, input int y, output int r, output int c);
        r = 0;
        c = 0;
        if (x < 80 || y < 0) return 1'b0;
        c = (x - 80) / 16;
        r = y / 16;
        return (c <= 29 && r <= 29);
    endfunction

    function automatic void model_paint(input int x, input int y);
        int r;
        int c;
        if (map_pen(x, y, r, c)) begin
`ifdef HANDWRITE_THICK_BRUSH_EN
            for (int rr = r - 1; rr <= r + 1; rr++) begin
                for (int cc = c - 1; cc <= c + 1; cc++) begin
                    if (rr >= 0 && rr <= 29 && cc >= 0 && cc <= 29) model_bm[10'(rr * 30 + cc)] = 1'b1;
                end
            end
`else
            model_bm[10'(r * 30 + c)] = 1'b1;
`endif
        end
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // One pen sample for one cycle in S_DRAW, model updated alongside.
    task automatic pen_sample(input int x, input int y);
        i_pen_x     = 10'(x);
        i_pen_y     = 10'(y);
        i_pen_valid = 1'b1;
        model_paint(x, y);
        step();
        i_pen_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int low_cnt;

        vecs[0] = '{x: 80,   y: 0,    valid: 1'b1};  // cell (0,0)
        vecs[1] = '{x: 559,  y: 479,  valid: 1'b1};  // cell (29,29)
        vecs[2] = '{x: 79,   y: 10,   valid: 1'b1};  // left of origin
        vecs[3] = '{x: 560,  y: 10,   valid: 1'b1};  // col 30
        vecs[4] = '{x: 100,  y: 480,  valid: 1'b1};  // row 30
        vecs[5] = '{x: 200,  y: 200,  valid: 1'b0};  // not qualified
        vecs[6] = '{x: 80,   y: 0,    valid: 1'b1};  // repeat of cell (0,0)
        vecs[7] = '{x: 95,   y: 15,   valid: 1'b1};  // same cell, far corner
        vecs[8] = '{x: 96,   y: 16,   valid: 1'b1};  // cell (1,1)
        vecs[9] = '{x: 1023, y: 1023, valid: 1'b1};  // far off canvas

        // Reset values while reset is held.
        #17;
        check_bm("reset bitmap", o_handwrite, '0);
        check("reset classify_n", 32'(o_classify_n), 32'd1);
        check("reset digit", 32'(o_digit), 32'd0);
        check("reset digit_valid", 32'(o_digit_valid), 32'd0);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset timeout", 32'(o_timeout), 32'd0);
        i_rst_n = 1'b1;
        step();

        // A result strobe outside S_WAIT must be ignored.
        i_digit       = 4'd3;
        i_digit_valid = 1'b1;
        step();
        i_digit_valid = 1'b0;
        check("stray result digit", 32'(o_digit), 32'd0);
        check("stray result valid", 32'(o_digit_valid), 32'd0);
        check("stray result busy", 32'(o_busy), 32'd0);

        // Table-driven pen samples through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            i_pen_x     = 10'(vecs[i].x);
            i_pen_y     = 10'(vecs[i].y);
            i_pen_valid = vecs[i].valid;
            if (vecs[i].valid) model_paint(vecs[i].x, vecs[i].y);
            exp_q.push_back(model_bm);
            step();
            i_pen_valid = 1'b0;
            check_bm($sformatf("pen vector %0d", i), o_handwrite, exp_q.pop_front());
        end

        // Clear: bits 0, 450, 899; clear+submit+pen in the same cycle, clear wins.
        pen_sample(80, 0);
        pen_sample(80, 240);
        pen_sample(559, 479);
        check_bm("pre-clear bitmap", o_handwrite, model_bm);
        i_clear     = 1'b1;
        i_submit    = 1'b1;
        i_pen_x     = 10'd100;
        i_pen_y     = 10'd100;
        i_pen_valid = 1'b1;
        step();
        i_clear     = 1'b0;
        i_submit    = 1'b0;
        i_pen_x     = 10'd80;
        i_pen_y     = 10'd0;
        check("clear beats submit", 32'(o_classify_n), 32'd1);
        check("clear busy cycle 0", 32'(o_busy), 32'd1);
        for (int k = 1; k < 30; k++) begin
            step();
            check($sformatf("clear busy cycle %0d", k), 32'(o_busy), 32'd1);
            if (k == 1) begin
                check("row 0 cleared first", 32'(o_handwrite[0]), 32'd0);
                check("row 15 not yet cleared", 32'(o_handwrite[450]), 32'd1);
            end
        end
        step();
        i_pen_valid = 1'b0;
        model_bm    = '0;
        check("clear done busy", 32'(o_busy), 32'd0);
        check_bm("cleared bitmap", o_handwrite, model_bm);

        // Submit with a classifier answering 902 cycles after the strobe.
        pen_sample(80, 240);
        i_submit = 1'b1;
        step();
        i_submit = 1'b0;
        check("strobe low", 32'(o_classify_n), 32'd0);
        check("fire busy", 32'(o_busy), 32'd1);
        i_pen_x     = 10'd300;
        i_pen_y     = 10'd300;
        i_pen_valid = 1'b1;
        i_clear     = 1'b1;
        step();
        i_clear = 1'b0;
        check("strobe released", 32'(o_classify_n), 32'd1);
        low_cnt = 0;
        for (int k = 2; k <= 901; k++) begin
            step();
            if (o_classify_n !== 1'b1) low_cnt++;
            i_submit = (k == 500);
        end
        check("strobe stays high in wait", 32'(low_cnt), 32'd0);
        check("busy before result", 32'(o_busy), 32'd1);
        i_digit       = 4'd7;
        i_digit_valid = 1'b1;
        step();
        i_digit_valid = 1'b0;
        i_pen_valid   = 1'b0;
        check("result digit", 32'(o_digit), 32'd7);
        check("result valid", 32'(o_digit_valid), 32'd1);
        check("result busy", 32'(o_busy), 32'd0);
        check("result no timeout", 32'(o_timeout), 32'd0);
        check_bm("bitmap frozen in wait", o_handwrite, model_bm);
        pen_sample(120, 40);
        check_bm("draw after result", o_handwrite, model_bm);
        check("valid held while drawing", 32'(o_digit_valid), 32'd1);

        // Submit with no response: timeout after the full wait.
        i_submit = 1'b1;
        step();
        i_submit = 1'b0;
        n = 0;
        while (!o_timeout && n < 2100) begin
            step();
            n++;
        end
        check("timeout latency", 32'(n), 32'd2049);
        check("timeout busy", 32'(o_busy), 32'd0);
        check("timeout keeps digit", 32'(o_digit), 32'd7);
        check("timeout drops valid", 32'(o_digit_valid), 32'd0);
        i_digit       = 4'd9;
        i_digit_valid = 1'b1;
        step();
        i_digit_valid = 1'b0;
        check("late result ignored", 32'(o_digit), 32'd7);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check("clear drops timeout", 32'(o_timeout), 32'd0);
        repeat (30) step();
        model_bm = '0;
        check("idle after clear", 32'(o_busy), 32'd0);

        // Result arriving on the final count wins over the timeout.
        i_submit = 1'b1;
        step();
        i_submit = 1'b0;
        repeat (2048) step();
        i_digit       = 4'd5;
        i_digit_valid = 1'b1;
        step();
        i_digit_valid = 1'b0;
        check("race result digit", 32'(o_digit), 32'd5);
        check("race result valid", 32'(o_digit_valid), 32'd1);
        check("race no timeout", 32'(o_timeout), 32'd0);
        check("race busy", 32'(o_busy), 32'd0);

        // Asynchronous reset in the middle of a wait.
        pen_sample(300, 300);
        i_submit = 1'b1;
        step();
        i_submit = 1'b0;
        repeat (10) step();
        i_rst_n = 1'b0;
        #1;
        model_bm = '0;
        check_bm("async reset bitmap", o_handwrite, model_bm);
        check("async reset busy", 32'(o_busy), 32'd0);
        check("async reset classify_n", 32'(o_classify_n), 32'd1);
        check("async reset digit", 32'(o_digit), 32'd0);
        check("async reset valid", 32'(o_digit_valid), 32'd0);
        check("async reset timeout", 32'(o_timeout), 32'd0);
        step();
        i_rst_n = 1'b1;
        step();
        pen_sample(559, 0);
        check_bm("draw after reset", o_handwrite, model_bm);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
